// File: rtl/tournament_grant_issuer_if.sv
// rtl/tournament_grant_issuer_if.sv - tournament winner / grant handshake bundle
interface tournament_grant_issuer_if #(
  parameter int NUM_UNITS   = 16,
  parameter int WIDTH_UNITS = 4
);

  logic [WIDTH_UNITS:0] I_Entry;
  logic [NUM_UNITS-1:0] I_Valid;
  logic [NUM_UNITS-1:0] I_Req;
  logic                 I_Ack;
  logic [NUM_UNITS-1:0] O_Grant;
  logic                 O_Grant_Valid;
  logic [WIDTH_UNITS:0] O_Entry;
  logic [NUM_UNITS-1:0] O_Mask;
  logic                 O_Busy;
  logic                 O_Timeout;

  // Tournament / requester side: drives winner, requests and ack.
  modport master (
    output I_Entry, I_Valid, I_Req, I_Ack,
    input  O_Grant, O_Grant_Valid, O_Entry, O_Mask, O_Busy, O_Timeout
  );

  // Grant issuer side.
  modport slave (
    input  I_Entry, I_Valid, I_Req, I_Ack,
    output O_Grant, O_Grant_Valid, O_Entry, O_Mask, O_Busy, O_Timeout
  );

endinterface

// File: rtl/tournament_grant_issuer.sv
// rtl/tournament_grant_issuer.sv - grant issuer with fairness mask; optional grant timeout under TOURNAMENT_TIMEOUT_EN
module tournament_grant_issuer #(
  parameter int NUM_UNITS      = 16,
  parameter int WIDTH_UNITS    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  tournament_grant_issuer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [NUM_UNITS-1:0] ONE_VEC = NUM_UNITS'(1);

  state_t               state_q, state_d;
  logic [NUM_UNITS-1:0] grant_q, grant_d;
  logic [NUM_UNITS-1:0] mask_q, mask_d;
  logic [WIDTH_UNITS:0] entry_q, entry_d;
  logic                 grant_valid_q, grant_valid_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_UNITS-1:0] elig;
  logic [NUM_UNITS-1:0] sel;
  logic [NUM_UNITS-1:0] mask_upd;
  logic                 req_g;
  logic                 timeout_hit;

`ifdef TOURNAMENT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_LAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  // Eligible units, lowest-index pick, and the granted unit's request level.
  always_comb begin
    elig  = bus.I_Valid & bus.I_Req & ~mask_q;
    sel   = elig & (~elig + ONE_VEC);
    req_g = |(bus.I_Req & grant_q);
  end

  // Fairness mask maintenance: drop idle units, restart round once every requester was served.
  always_comb begin
    mask_upd = mask_q & bus.I_Req;
    if (((bus.I_Req & ~mask_q) == '0) && (bus.I_Req != '0)) begin
      mask_upd = '0;
    end
  end

  // Next-state and registered-output computation for the grant FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    entry_d   = entry_q;
    mask_d    = mask_q;
    timeout_d = 1'b0;
`ifdef TOURNAMENT_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        mask_d = mask_upd;
        if (elig != '0) begin
          grant_d = sel;
          entry_d = bus.I_Entry;
          state_d = ST_GRANT;
`ifdef TOURNAMENT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (bus.I_Ack) begin
          mask_d  = mask_q | grant_q;
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (timeout_hit) begin
          // Penalise a unit that never acknowledged.
          mask_d    = mask_q | grant_q;
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else if (!req_g) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else begin
`ifdef TOURNAMENT_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        mask_d  = mask_upd;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    grant_valid_d = (state_d == ST_GRANT);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      mask_q        <= '0;
      entry_q       <= '0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      mask_q        <= mask_d;
      entry_q       <= entry_d;
      grant_valid_q <= grant_valid_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef TOURNAMENT_TIMEOUT_EN
  // Grant-duration counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.O_Grant       = grant_q;
  assign bus.O_Grant_Valid = grant_valid_q;
  assign bus.O_Entry       = entry_q;
  assign bus.O_Mask        = mask_q;
  assign bus.O_Busy        = busy_q;
  assign bus.O_Timeout     = timeout_q;

endmodule

// File: doc/tournament_grant_issuer.md
# tournament_grant_issuer

Sequential grant issuer on the consumer side of the TournamentL largest-value selector. It samples the combinational winner (entry plus one-hot valid vector) and latches one unit. It then drives a grant/acknowledge handshake with that unit. It also keeps a fairness mask that the surrounding logic ANDs into the tournament inputs, so a served unit stays out until every other requester has been served.

## Interface
Parameters:
- NUM_UNITS, 16, number of competing units (width of every per-unit vector)
- WIDTH_UNITS, 4, entry width minus one (entries are WIDTH_UNITS+1 bits)
- TIMEOUT_CYCLES, 256, grant timeout; used only when TOURNAMENT_TIMEOUT_EN is defined

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- I_Entry  in  WIDTH_UNITS+1  winning entry value from the tournament
- I_Valid  in  NUM_UNITS  winner flags from the tournament (one-hot expected)
- I_Req  in  NUM_UNITS  per-unit request level
- I_Ack  in  1  acknowledge from the granted unit
- O_Grant  out  NUM_UNITS  one-hot grant, held for the whole grant
- O_Grant_Valid  out  1  grant outstanding
- O_Entry  out  WIDTH_UNITS+1  latched entry of the granted unit
- O_Mask  out  NUM_UNITS  fairness mask; 1 = unit excluded from the tournament
- O_Busy  out  1  FSM is not IDLE
- O_Timeout  out  1  one-cycle pulse on grant abort

## Operation
- Eligible vector E = I_Valid & I_Req & ~O_Mask.
- Selection: the lowest set index of E is chosen. This resolves multi-hot ties deterministically.
- FSM states:
  - IDLE
    - If E != 0: latch the selected one-hot into O_Grant and I_Entry into O_Entry, then go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT
    - O_Grant_Valid=1.
    - If I_Ack=1: set O_Mask[g] and go to RELEASE.
    - Else if I_Req[g]=0 (withdraw): go to RELEASE with the mask unchanged.
    - When ack and withdraw occur in the same cycle, the ack wins.
  - RELEASE
    - O_Grant_Valid=0 and O_Grant cleared. O_Entry keeps its last value.
    - Apply the mask update rule below, then go to IDLE.
- Mask update, evaluated in RELEASE and every IDLE cycle:
  - A bit clears when its I_Req is 0.
  - If (I_Req & ~O_Mask) == 0 and I_Req != 0, the whole mask clears. This starts a new fairness round.
- Entries with value 0 are legal. Only I_Valid/I_Req decide eligibility.

## Timing
- Reset values:
  - FSM=IDLE.
  - O_Grant=0, O_Grant_Valid=0, O_Entry=0, O_Mask=0, O_Busy=0, O_Timeout=0.
  - Timeout counter=0.
- Reset asserted mid-grant: all outputs drop asynchronously. There is no pending ack memory.
- All outputs are registered.
- Latency:
  - E nonzero in IDLE at cycle t → O_Grant_Valid=1 at t+1.
  - I_Ack at t (while GRANT) → RELEASE at t+1, with O_Grant_Valid=0 and the mask bit set.
  - The next IDLE sample happens at t+2, so the earliest next grant is t+3.
- I_Ack is ignored outside GRANT.
- I_Valid/I_Req changes after latching do not alter O_Grant/O_Entry.
- O_Busy=1 in GRANT and RELEASE.

## Configuration
- Macro TOURNAMENT_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to GRANT and increments each GRANT cycle without ack.
  - If the count reaches TIMEOUT_CYCLES-1 and I_Ack=0 in that cycle: O_Timeout pulses for 1 cycle at the transition, O_Mask[g] is set (penalty), and the FSM goes to RELEASE.
  - An ack in the terminal cycle wins, with no pulse.
- Undefined:
  - There is no counter; GRANT waits indefinitely.
  - O_Timeout is tied to 0.

## Test plan
- Reset then single request:
  - Stimulus: I_Req=0x0010, I_Valid=0x0010, I_Entry=5'h1A.
  - Response: grant at +1 with O_Grant=0x0010 and O_Entry=0x1A.
  - Then: I_Ack 3 cycles later → O_Grant_Valid=0 next cycle and O_Mask=0x0010; because no other unit requests, the mask clears to 0x0000 in RELEASE.
- Fairness:
  - Stimulus: I_Req=0x0003 held, with the tournament model honoring O_Mask; unit 1 has the larger value.
  - Response: grants alternate 0x0002, 0x0001, 0x0002, and the mask clears after both units are served.
- Multi-hot tie:
  - Stimulus: I_Valid=0x0A00, I_Req=0x0A00.
  - Response: O_Grant=0x0200.
- Withdraw:
  - Stimulus: in GRANT to unit 3, drop I_Req[3] with no ack.
  - Response: RELEASE, O_Mask[3]=0, O_Timeout=0.
  - Then: a same-cycle ack+withdraw → mask bit set.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - Stimulus: grant unit 7 and never ack.
  - Response: O_Timeout pulses exactly at GRANT cycle 8, then O_Mask=0x0080 and O_Grant_Valid=0 next cycle.
  - Macro undefined: the grant stays held for more than 1000 cycles.
- Async reset mid-grant:
  - Stimulus: assert reset between edges while in GRANT.
  - Response: all outputs go to 0 immediately; after release with I_Req=0, the block stays in IDLE.
